// File: rtl/ram_access_arbiter.sv
// ram_access_arbiter: shares one byte-addressed RAM between a word-fetch port and a load/store port.
module ram_access_arbiter #(
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 32,
  parameter int MAX_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_err,
  input  logic              d_req,
  input  logic              d_rw,
  input  logic [1:0]        d_size,
  input  logic              d_se,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic              ram_e,
  output logic              ram_rw,
  output logic [1:0]        ram_size,
  output logic              ram_se,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t            state_q, state_d;
  logic [3:0]        streak_q, streak_d;
  logic              sel_q, sel_d, err_q, err_d, busy_q, busy_d;
  logic              ram_e_q, ram_e_d, ram_rw_q, ram_rw_d, ram_se_q, ram_se_d;
  logic [1:0]        ram_size_q, ram_size_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_din_q, ram_din_d, if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic              if_ack_q, if_ack_d, d_ack_q, d_ack_d, if_err_q, if_err_d, d_err_q, d_err_d;
  logic              grant_if;
  always_comb begin
    state_d    = state_q;
    streak_d   = streak_q;
    sel_d      = sel_q;
    err_d      = err_q;
    busy_d     = busy_q;
    ram_e_d    = ram_e_q;
    ram_rw_d   = ram_rw_q;
    ram_se_d   = ram_se_q;
    ram_size_d = ram_size_q;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    if_ack_d   = 1'b0;
    d_ack_d    = 1'b0;
    if_err_d   = 1'b0;
    d_err_d    = 1'b0;
    if_rdata_d = '0;
    d_rdata_d  = '0;
    grant_if   = if_req && (!d_req || streak_q >= 4'(MAX_STREAK));
    if (state_q == IDLE && (if_req || d_req)) begin
      state_d    = ACCESS;
      busy_d     = 1'b1;
      sel_d      = grant_if;
      streak_d   = grant_if ? 4'd0 : (streak_q == 4'hf ? streak_q : streak_q + 4'd1);
      err_d      = grant_if ? |if_addr[1:0] :
                   (d_size == 2'b11) || (d_size == 2'b01 && d_addr[0]) || (d_size == 2'b10 && |d_addr[1:0]);
      ram_e_d    = !err_d;
      ram_rw_d   = !grant_if && d_rw;
      ram_se_d   = !grant_if && d_se;
      ram_size_d = grant_if ? 2'b10 : d_size;
      ram_addr_d = grant_if ? if_addr : d_addr;
      ram_din_d  = grant_if ? '0 : d_wdata;
    end else if (state_q == ACCESS) begin
      state_d    = RESP;
      ram_e_d    = 1'b0;
      ram_rw_d   = 1'b0;
      if_ack_d   = sel_q;
      d_ack_d    = !sel_q;
      if_err_d   = sel_q && err_q;
      d_err_d    = !sel_q && err_q;
      if_rdata_d = (sel_q && !err_q) ? ram_dout : '0;
      d_rdata_d  = (!sel_q && !err_q && !ram_rw_q) ? ram_dout : '0;
    end else if (state_q == RESP) begin
      state_d    = IDLE;
      busy_d     = 1'b0;
    end
    if (!if_req) streak_d = 4'd0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      streak_q   <= '0;
      sel_q      <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      ram_e_q    <= 1'b0;
      ram_rw_q   <= 1'b0;
      ram_se_q   <= 1'b0;
      ram_size_q <= '0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      if_ack_q   <= 1'b0;
      d_ack_q    <= 1'b0;
      if_err_q   <= 1'b0;
      d_err_q    <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      streak_q   <= streak_d;
      sel_q      <= sel_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      ram_e_q    <= ram_e_d;
      ram_rw_q   <= ram_rw_d;
      ram_se_q   <= ram_se_d;
      ram_size_q <= ram_size_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
      if_ack_q   <= if_ack_d;
      d_ack_q    <= d_ack_d;
      if_err_q   <= if_err_d;
      d_err_q    <= d_err_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end
  assign if_ack   = if_ack_q;
  assign if_err   = if_err_q;
  assign if_rdata = if_rdata_q;
  assign d_ack    = d_ack_q;
  assign d_err    = d_err_q;
  assign d_rdata  = d_rdata_q;
  assign ram_e    = ram_e_q;
  assign ram_rw   = ram_rw_q;
  assign ram_se   = ram_se_q;
  assign ram_size = ram_size_q;
  assign ram_addr = ram_addr_q;
  assign ram_din  = ram_din_q;
  assign busy     = busy_q;
endmodule

// File: tb/tb_ram_access_arbiter.sv
// tb_ram_access_arbiter: directed and random checks of the RAM arbiter against a byte-array model.
module tb_ram_access_arbiter;
  logic        clk, rst_n;
  logic        if_req, if_ack, if_err, d_req, d_rw, d_se, d_ack, d_err;
  logic [8:0]  if_addr, d_addr, ram_addr;
  logic [1:0]  d_size, ram_size;
  logic [31:0] if_rdata, d_wdata, d_rdata, ram_din, ram_dout;
  logic        ram_e, ram_rw, ram_se, busy;
  logic [7:0]  sm [512];
  logic [7:0]  ram_mem [512];
  logic [7:0]  b0, b1, b2, b3;
  int          n_chk = 0, n_fail = 0;

  ram_access_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_rw(d_rw), .d_size(d_size), .d_se(d_se), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .ram_e(ram_e), .ram_rw(ram_rw), .ram_size(ram_size), .ram_se(ram_se), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Big-endian RAM: contents reload from the shadow while reset is held.
  assign b0 = ram_mem[ram_addr];
  assign b1 = ram_mem[ram_addr + 9'd1];
  assign b2 = ram_mem[ram_addr + 9'd2];
  assign b3 = ram_mem[ram_addr + 9'd3];
  assign ram_dout = ram_size == 2'b00 ? {{24{ram_se & b0[7]}}, b0} :
                    ram_size == 2'b01 ? {{16{ram_se & b0[7]}}, b0, b1} : {b0, b1, b2, b3};
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 512; i++) ram_mem[i] <= sm[i];
    end else if (ram_e && ram_rw) begin
      if (ram_size == 2'b00) ram_mem[ram_addr] <= ram_din[7:0];
      else if (ram_size == 2'b01) begin
        ram_mem[ram_addr] <= ram_din[15:8];
        ram_mem[ram_addr + 9'd1] <= ram_din[7:0];
      end else begin
        ram_mem[ram_addr] <= ram_din[31:24];
        ram_mem[ram_addr + 9'd1] <= ram_din[23:16];
        ram_mem[ram_addr + 9'd2] <= ram_din[15:8];
        ram_mem[ram_addr + 9'd3] <= ram_din[7:0];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return sz == 2'b00 ? 1 : sz == 2'b01 ? 2 : 4;
  endfunction

  function automatic logic [31:0] model(input logic [8:0] a, input logic [1:0] sz, input logic se);
    int n = nbytes(sz);
    logic [31:0] v = 0;
    for (int i = 0; i < n; i++) v = (v << 8) | 32'(sm[(int'(a) + i) % 512]);
    if (se && n < 4 && v[8*n-1]) v = v | (32'hffffffff << (8*n));
    return v;
  endfunction

  task automatic data_op(input logic rw, input logic [1:0] sz, input logic se, input logic [8:0] a, input logic [31:0] wd);
    int lat = 0, n = nbytes(sz);
    logic saw_e = 1'b0;
    logic err = (sz == 2'b11) || (int'(a) % n != 0);
    logic [31:0] exp = (err || rw) ? 32'h0 : model(a, sz, se);
    d_rw = rw; d_size = sz; d_se = se; d_addr = a; d_wdata = wd; d_req = 1'b1;
    while (!d_ack && lat < 10) begin
      @(negedge clk);
      lat++;
      saw_e |= ram_e;
    end
    d_req = 1'b0;
    chk("d_latency", 32'(lat), 32'd2);
    chk("d_err", {31'b0, d_err}, {31'b0, err});
    chk("d_rdata", d_rdata, exp);
    chk("d_ram_e_seen", {31'b0, saw_e}, {31'b0, !err});
    chk("d_other_ack", {31'b0, if_ack}, 32'd0);
    if (!err && rw)
      for (int i = 0; i < n; i++) sm[int'(a) + i] = 8'(wd >> (8*(n-1-i)));
    @(negedge clk);
  endtask

  task automatic fetch_op(input logic [8:0] a);
    int lat = 0;
    logic saw_e = 1'b0;
    logic err = |a[1:0];
    logic [31:0] exp = err ? 32'h0 : model(a, 2'b10, 1'b0);
    if_addr = a; if_req = 1'b1;
    while (!if_ack && lat < 10) begin
      @(negedge clk);
      lat++;
      saw_e |= ram_e;
    end
    if_req = 1'b0;
    chk("if_latency", 32'(lat), 32'd2);
    chk("if_err", {31'b0, if_err}, {31'b0, err});
    chk("if_rdata", if_rdata, exp);
    chk("if_ram_e_seen", {31'b0, saw_e}, {31'b0, !err});
    chk("if_other_ack", {31'b0, d_ack}, 32'd0);
    @(negedge clk);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk(tag, {if_ack, if_err, d_ack, d_err, ram_e, ram_rw, ram_se, busy, ram_size}, 32'd0);
    chk(tag, if_rdata | d_rdata | ram_din | {23'b0, ram_addr}, 32'd0);
  endtask

  initial begin
    int k, cyc;
    logic [8:0] a;
    logic fetch_exp;
    rst_n = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_rw = 1'b0;
    d_size = '0; d_se = 1'b0; d_addr = '0; d_wdata = '0;
    for (int i = 0; i < 512; i++) sm[i] = 8'($urandom);
    sm[0] = 8'h8c; sm[1] = 8'ha0; sm[2] = 8'h00; sm[3] = 8'h01; sm[4] = 8'hf3;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset_state");
    rst_n = 1'b1;
    @(negedge clk);
    fetch_op(9'd0);
    data_op(1'b0, 2'b00, 1'b1, 9'd4, 32'h0);
    data_op(1'b0, 2'b00, 1'b0, 9'd4, 32'h0);
    data_op(1'b1, 2'b01, 1'b0, 9'd2, 32'h000035ad);
    data_op(1'b0, 2'b01, 1'b1, 9'd2, 32'h0);
    data_op(1'b0, 2'b10, 1'b0, 9'd6, 32'h0);
    data_op(1'b0, 2'b01, 1'b0, 9'd3, 32'h0);
    data_op(1'b1, 2'b11, 1'b0, 9'd8, 32'hdeadbeef);
    fetch_op(9'd2);
    // Both requesters held: four data grants, then the fetch, repeating.
    d_rw = 1'b0; d_size = 2'b00; d_se = 1'b1; d_addr = 9'd4; if_addr = 9'd0;
    d_req = 1'b1; if_req = 1'b1;
    k = 0; cyc = 0;
    while (k < 10 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (if_ack || d_ack) begin
        fetch_exp = (k % 5 == 4);
        chk("starve_order", {30'b0, if_ack, d_ack}, fetch_exp ? 32'd2 : 32'd1);
        if (fetch_exp) chk("starve_fetch_data", if_rdata, model(9'd0, 2'b10, 1'b0));
        else chk("starve_load_data", d_rdata, model(9'd4, 2'b00, 1'b1));
        k++;
      end
    end
    d_req = 1'b0; if_req = 1'b0;
    chk("starve_ack_count", 32'(k), 32'd10);
    @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      a = 9'($urandom);
      if ($urandom_range(0, 4) == 0) fetch_op($urandom_range(0, 3) == 0 ? a : {a[8:2], 2'b00});
      else data_op(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom);
    end
    // Reset in the middle of a store's RAM cycle.
    d_rw = 1'b1; d_size = 2'b10; d_se = 1'b0; d_addr = 9'd8; d_wdata = $urandom; d_req = 1'b1;
    @(posedge clk);
    #2;
    chk("rst_pre_access", {30'b0, ram_e, busy}, 32'd3);
    rst_n = 1'b0;
    #1;
    chk("rst_async_drop", {29'b0, ram_e, ram_rw, busy}, 32'd0);
    d_req = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_no_ack", {30'b0, d_ack, if_ack}, 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle_outputs("post_reset");
    fetch_op(9'd8);
    data_op(1'b0, 2'b00, 1'b1, 9'd4, 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
